// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_tx_sched slice.
//   sched_state_t : scheduler FSM states
//   UART_MIN_LEN / UART_MAX_LEN : legal data-bit range of a uart_tx frame
//   uart_len_ok() : true when a requested frame length is legal
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } sched_state_t;

  localparam logic [3:0] UART_MIN_LEN = 4'd5;
  localparam logic [3:0] UART_MAX_LEN = 4'd8;

  function automatic logic uart_len_ok(input logic [3:0] len);
    return (len >= UART_MIN_LEN) && (len <= UART_MAX_LEN);
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
//   req        : request vector
//   ptr        : highest-priority index this cycle
//   win_onehot : one-hot winner (first set bit at or after ptr, wrapping)
//   win_idx    : binary index of the winner
//   valid      : at least one request present
module uart_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0]   win_idx,
  output logic               valid
);

  int unsigned pos;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    valid      = 1'b0;
    pos        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = (32'(ptr) + k) % NUM_REQ;
      if (!valid && req[pos]) begin
        valid           = 1'b1;
        win_idx         = IDX_W'(pos);
        win_onehot[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ requesters.
// Optional feature macro: UART_TX_SCHED_TIMEOUT_EN (WAIT-state watchdog).
// Ports:
//   tx_clk, rst          : clock and synchronous active-high reset
//   req / req_*          : per-requester request level, byte and frame format
//   gnt                  : combinational one-hot grant (IDLE only)
//   frame_done, cfg_err  : one-hot completion / illegal-length pulses
//   timeout_err          : watchdog abort pulse (0 without the macro)
//   busy                 : high in LAUNCH and WAIT
//   ut_*                 : registered drive of the uart_tx inputs
//   ut_done              : uart_tx.tx_done
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic                 tx_clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ*4-1:0] req_length,
  input  logic [NUM_REQ-1:0]   req_parity_en,
  input  logic [NUM_REQ-1:0]   req_parity_type,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   frame_done,
  output logic [NUM_REQ-1:0]   cfg_err,
  output logic                 timeout_err,
  output logic                 busy,
  output logic                 ut_start,
  output logic [7:0]           ut_data,
  output logic [3:0]           ut_length,
  output logic                 ut_parity_en,
  output logic                 ut_parity_type,
  input  logic                 ut_done
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  sched_state_t       state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   win_q;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  logic [7:0]         sel_data;
  logic [3:0]         sel_len;
  logic               sel_pe;
  logic               sel_pt;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    if (32'(i) == NUM_REQ - 1) return '0;
    else                       return i + IDX_W'(1);
  endfunction

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req),
    .ptr        (ptr),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .valid      (pick_valid)
  );

  // Route the winner's request fields to the latch inputs.
  always_comb begin
    sel_data = '0;
    sel_len  = '0;
    sel_pe   = 1'b0;
    sel_pt   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) begin
        sel_data = req_data[8*i +: 8];
        sel_len  = req_length[4*i +: 4];
        sel_pe   = req_parity_en[i];
        sel_pt   = req_parity_type[i];
      end
    end
  end

  // Grant is combinational; masked during reset so it reads 0 there.
  assign gnt  = (state == IDLE && !rst) ? pick_onehot : '0;
  assign busy = (state != IDLE);

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;
  assign timeout_err = timeout_q;
`else
  // TIMEOUT_CYCLES is only meaningful with the watchdog built in.
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES == 0);
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= '0;
      win_q          <= '0;
      ut_start       <= 1'b0;
      ut_data        <= '0;
      ut_length      <= '0;
      ut_parity_en   <= 1'b0;
      ut_parity_type <= 1'b0;
      frame_done     <= '0;
      cfg_err        <= '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      wait_cnt       <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      ut_start   <= 1'b0;
      frame_done <= '0;
      cfg_err    <= '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_valid) begin
            win_q <= pick_idx;
            if (uart_len_ok(sel_len)) begin
              ut_data        <= sel_data;
              ut_length      <= sel_len;
              ut_parity_en   <= sel_pe;
              ut_parity_type <= sel_pt;
              ut_start       <= 1'b1;
              state          <= LAUNCH;
            end else begin
              cfg_err <= pick_onehot;
              ptr     <= wrap_inc(pick_idx);
            end
          end
        end
        LAUNCH: begin
          state <= WAIT;
`ifdef UART_TX_SCHED_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (ut_done) begin
            frame_done <= NUM_REQ'(1) << win_q;
            ptr        <= wrap_inc(win_q);
            state      <= IDLE;
          end
`ifdef UART_TX_SCHED_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_q <= 1'b1;
            ptr       <= wrap_inc(win_q);
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
